lfsr_run_ctrl: RTL and testbench

- Sequencer for the team's `lfsr` block. It accepts a seed and run-length request, then loads the seed through `mode`/`p_in`.
- It then steps the LFSR in shift mode and watches `status` to measure the sequence period or stop at a step limit.
- It sits between a host and one `lfsr` instance: host → `lfsr_run_ctrl` → `lfsr`.

---
 rtl/lfsr_run_ctrl_if.sv | 27 ++
 rtl/lfsr_run_ctrl.sv | 120 ++++++++++++
 tb/tb_lfsr_run_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_run_ctrl_if.sv
// Host-side request/result bundle for lfsr_run_ctrl.
// The host drives the master modport and the controller implements the slave modport.
interface lfsr_run_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             start;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] run_len;
    logic             stop_on_period;
    logic             busy;
    logic             done;
    logic             period_found;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] steps;
    logic             err_seed;

    modport master (
        output start, seed, run_len, stop_on_period,
        input  busy, done, period_found, period, steps, err_seed
    );

    modport slave (
        input  start, seed, run_len, stop_on_period,
        output busy, done, period_found, period, steps, err_seed
    );
endinterface

// File: rtl/lfsr_run_ctrl.sv
// Sequencer that seeds an external lfsr, steps it and measures the period or stops at a step limit.
// Optional LFSR_RUN_TRACE_EN adds a registered per-RUN-cycle trace of lfsr_status.
module lfsr_run_ctrl #(
    parameter int unsigned      WIDTH        = 4,
    parameter int unsigned      CNT_W        = 8,
    parameter logic [WIDTH-1:0] LOCKUP_STATE = '0
) (
    input  logic             clk,
    input  logic             reset,
    lfsr_run_ctrl_if.slave   host,
    output logic             lfsr_mode,
    output logic [WIDTH-1:0] lfsr_p_in,
    input  logic [WIDTH-1:0] lfsr_status
`ifdef LFSR_RUN_TRACE_EN
    ,
    output logic             trace_valid,
    output logic [WIDTH-1:0] trace_data
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] run_len_q;
    logic             stop_on_period_q;
    logic [CNT_W-1:0] cnt;
    logic             period_hit_c;

    // Seed register doubles as the parallel-load value, so IDLE/LOAD/DONE all present it.
    assign lfsr_p_in = seed_q;

    // Step 0 is the freshly loaded seed and never counts as a return to it.
    assign period_hit_c = (cnt != '0) && (lfsr_status == seed_q) && !host.period_found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            seed_q            <= '0;
            run_len_q         <= '0;
            stop_on_period_q  <= 1'b0;
            cnt               <= '0;
            lfsr_mode         <= 1'b0;
            host.busy         <= 1'b0;
            host.done         <= 1'b0;
            host.period_found <= 1'b0;
            host.period       <= '0;
            host.steps        <= '0;
            host.err_seed     <= 1'b0;
`ifdef LFSR_RUN_TRACE_EN
            trace_valid       <= 1'b0;
            trace_data        <= '0;
`endif
        end else begin
            host.done     <= 1'b0;
            host.err_seed <= 1'b0;
`ifdef LFSR_RUN_TRACE_EN
            trace_valid   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (host.start) begin
                        if (host.seed == LOCKUP_STATE) begin
                            host.err_seed <= 1'b1;
                        end else begin
                            seed_q            <= host.seed;
                            run_len_q         <= host.run_len;
                            stop_on_period_q  <= host.stop_on_period;
                            host.period_found <= 1'b0;
                            host.period       <= '0;
                            cnt               <= '0;
                            host.busy         <= 1'b1;
                            state             <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    lfsr_mode <= 1'b1;
                    state     <= RUN;
                end

                RUN: begin
`ifdef LFSR_RUN_TRACE_EN
                    trace_valid <= 1'b1;
                    trace_data  <= lfsr_status;
`endif
                    if (period_hit_c) begin
                        host.period       <= cnt;
                        host.period_found <= 1'b1;
                    end
                    // Exit on a stopping period hit, otherwise at the step limit.
                    if ((period_hit_c && stop_on_period_q) || (cnt == run_len_q)) begin
                        host.steps <= cnt;
                        host.busy  <= 1'b0;
                        host.done  <= 1'b1;
                        lfsr_mode  <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_run_ctrl.sv
// Scoreboard bench for lfsr_run_ctrl driving a behavioural x^4+x^3+1 LFSR.
// Expected results are queued at start and checked when done pulses.
module tb_lfsr_run_ctrl;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic             pf;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] steps;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             lfsr_mode;
    logic [WIDTH-1:0] lfsr_p_in;
    logic [WIDTH-1:0] lfsr_status;
`ifdef LFSR_RUN_TRACE_EN
    logic             trace_valid;
    logic [WIDTH-1:0] trace_data;
    logic [WIDTH-1:0] trace_q[$];
`endif

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lfsr_run_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) host_if ();

    lfsr_run_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .LOCKUP_STATE(4'b0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .host        (host_if),
        .lfsr_mode   (lfsr_mode),
        .lfsr_p_in   (lfsr_p_in),
        .lfsr_status (lfsr_status)
`ifdef LFSR_RUN_TRACE_EN
        ,
        .trace_valid (trace_valid),
        .trace_data  (trace_data)
`endif
    );

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return {s[2:0], s[3] ^ s[2]};
    endfunction

    // Behavioural lfsr: mode 0 loads p_in, mode 1 shifts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr_status <= '0;
        else if (lfsr_mode) lfsr_status <= lfsr_next(lfsr_status);
        else lfsr_status <= lfsr_p_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop on every done pulse.
    always @(negedge clk) begin
        if (host_if.done === 1'b1) begin
            check("sb_depth", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("period_found", 32'(host_if.period_found), 32'(e.pf));
                check("period", 32'(host_if.period), 32'(e.period));
                check("steps", 32'(host_if.steps), 32'(e.steps));
                check("mode_in_done", 32'(lfsr_mode), 32'd0);
            end
        end
    end

`ifdef LFSR_RUN_TRACE_EN
    always @(negedge clk) begin
        if (trace_valid === 1'b1) trace_q.push_back(trace_data);
    end
`endif

    task automatic run_job(input logic [WIDTH-1:0] sd, input logic [CNT_W-1:0] rl,
                           input logic sop, input exp_t e, input bit inject);
        int lat;
        int busy_n;
        bit seen;
        lat    = 0;
        busy_n = 0;
        seen   = 1'b0;
        @(negedge clk);
        host_if.seed           = sd;
        host_if.run_len        = rl;
        host_if.stop_on_period = sop;
        host_if.start          = 1'b1;
        sb_q.push_back(e);
        @(posedge clk);
        #1 host_if.start = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (host_if.busy) busy_n++;
            if (inject && lat == 5) begin
                host_if.seed  = 4'b0110;
                host_if.start = 1'b1;
            end
            if (inject && lat == 6) begin
                host_if.start = 1'b0;
                host_if.seed  = sd;
            end
            if (inject && lat == 7) check("p_in_hold", 32'(lfsr_p_in), 32'(sd));
            if (host_if.done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_latency", 32'(lat), 32'(e.steps) + 32'd3);
        check("busy_cycles", 32'(busy_n), 32'(e.steps) + 32'd2);
        check("busy_in_done", 32'(host_if.busy), 32'd0);
        repeat (3) @(negedge clk);
        check("busy_after", 32'(host_if.busy), 32'd0);
    endtask

    initial begin
        reset                  = 1'b1;
        host_if.start          = 1'b0;
        host_if.seed           = '0;
        host_if.run_len        = '0;
        host_if.stop_on_period = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(host_if.busy), 32'd0);
        check("rst_done", 32'(host_if.done), 32'd0);
        check("rst_pf", 32'(host_if.period_found), 32'd0);
        check("rst_period", 32'(host_if.period), 32'd0);
        check("rst_steps", 32'(host_if.steps), 32'd0);
        check("rst_err", 32'(host_if.err_seed), 32'd0);
        check("rst_mode", 32'(lfsr_mode), 32'd0);
        check("rst_p_in", 32'(lfsr_p_in), 32'd0);
        reset = 1'b0;

        // Period search with trace capture.
`ifdef LFSR_RUN_TRACE_EN
        trace_q.delete();
`endif
        run_job(4'b1111, 8'd40, 1'b1, '{pf: 1'b1, period: 8'd15, steps: 8'd15}, 1'b0);
`ifdef LFSR_RUN_TRACE_EN
        begin
            logic [WIDTH-1:0] s;
            s = 4'b1111;
            check("trace_len", 32'(trace_q.size()), 32'd16);
            for (int i = 0; i < 16; i++) begin
                if (i < trace_q.size()) check("trace_data", 32'(trace_q[i]), 32'(s));
                s = lfsr_next(s);
            end
        end
`endif

        // Step limit reached before the period.
        run_job(4'b1001, 8'd10, 1'b1, '{pf: 1'b0, period: 8'd0, steps: 8'd10}, 1'b0);

        // Full run keeps going after the period is found.
        run_job(4'b0001, 8'd40, 1'b0, '{pf: 1'b1, period: 8'd15, steps: 8'd40}, 1'b0);

        // Lock-up seed rejected.
        @(negedge clk);
        host_if.seed  = 4'b0000;
        host_if.start = 1'b1;
        @(posedge clk);
        #1 host_if.start = 1'b0;
        check("err_seed_pulse", 32'(host_if.err_seed), 32'd1);
        check("err_busy", 32'(host_if.busy), 32'd0);
        @(posedge clk);
        #1;
        check("err_seed_clear", 32'(host_if.err_seed), 32'd0);
        check("err_busy2", 32'(host_if.busy), 32'd0);

        // Start during RUN is ignored.
        run_job(4'b1111, 8'd40, 1'b1, '{pf: 1'b1, period: 8'd15, steps: 8'd15}, 1'b1);

        // Zero-length run.
        run_job(4'b0110, 8'd0, 1'b1, '{pf: 1'b0, period: 8'd0, steps: 8'd0}, 1'b0);

        // Asynchronous reset mid-run.
        @(negedge clk);
        host_if.seed           = 4'b1001;
        host_if.run_len        = 8'd40;
        host_if.stop_on_period = 1'b0;
        host_if.start          = 1'b1;
        @(posedge clk);
        #1 host_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(host_if.busy), 32'd0);
        check("mid_rst_mode", 32'(lfsr_mode), 32'd0);
        check("mid_rst_steps", 32'(host_if.steps), 32'd0);
        check("mid_rst_period", 32'(host_if.period), 32'd0);
        check("mid_rst_pf", 32'(host_if.period_found), 32'd0);
        check("mid_rst_p_in", 32'(lfsr_p_in), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_job(4'b1001, 8'd10, 1'b1, '{pf: 1'b0, period: 8'd0, steps: 8'd10}, 1'b0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
